// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage data bus between the pipeline (master) and the
// data-memory responder (slave).
//   dmem_action_cyc / dmem_action_stb : bus cycle active / request strobe
//   dmem_write, dmem_byte_enable      : request type and byte lanes
//   dmem_address, dmem_wdata          : byte address and write data
//   dmem_resp, dmem_data_out, dmem_err: one-cycle ack, read data, range error
interface dmem_responder_if;
  logic        dmem_action_cyc;
  logic        dmem_action_stb;
  logic        dmem_write;
  logic [1:0]  dmem_byte_enable;
  logic [15:0] dmem_address;
  logic [15:0] dmem_wdata;
  logic        dmem_resp;
  logic [15:0] dmem_data_out;
  logic        dmem_err;

  modport master (
    output dmem_action_cyc, dmem_action_stb, dmem_write, dmem_byte_enable,
           dmem_address, dmem_wdata,
    input  dmem_resp, dmem_data_out, dmem_err
  );

  modport slave (
    input  dmem_action_cyc, dmem_action_stb, dmem_write, dmem_byte_enable,
           dmem_address, dmem_wdata,
    output dmem_resp, dmem_data_out, dmem_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with programmable
// wait states and a word-organised 16-bit SRAM model.
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset (array contents are not reset)
//   bus   : dmem_responder_if slave modport (request in, resp/data/err out)
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for cyc & stb; request fields latched on accept
//   WAIT  | down-counting wait states; cyc low aborts back to IDLE
//   ACK   | dmem_resp (and dmem_err) high for this one cycle
module dmem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;

  logic              lat_write;
  logic [1:0]        lat_be;
  logic [15:0]       lat_addr;
  logic [15:0]       lat_wdata;

  logic              resp_q;
  logic              err_q;
  logic [15:0]       data_q;

  logic [15:0]       mem [DEPTH];

  logic              req;
  logic              enter_ack;
  logic              cm_write;
  logic [1:0]        cm_be;
  logic [15:0]       cm_addr;
  logic [15:0]       cm_wdata;
  logic              cm_oor;
  logic [ADDR_WIDTH-1:0] cm_idx;

  assign req = bus.dmem_action_cyc & bus.dmem_action_stb;

  // Request fields in force on the edge that enters ACK. With zero wait states
  // that edge is also the accept edge, so the live inputs are used instead of
  // the (not yet loaded) latches.
  always_comb begin
    enter_ack = 1'b0;
    cm_write  = lat_write;
    cm_be     = lat_be;
    cm_addr   = lat_addr;
    cm_wdata  = lat_wdata;
    case (state)
      IDLE: begin
        if (LATENCY == 0 && req) begin
          enter_ack = 1'b1;
          cm_write  = bus.dmem_write;
          cm_be     = bus.dmem_byte_enable;
          cm_addr   = bus.dmem_address;
          cm_wdata  = bus.dmem_wdata;
        end
      end
      WAIT:    enter_ack = bus.dmem_action_cyc && (cnt == '0);
      default: enter_ack = 1'b0;
    endcase
  end

  assign cm_idx = cm_addr[ADDR_WIDTH:1];
  // Any set bit above the word index puts the byte address outside the array.
  assign cm_oor = (cm_addr >> (ADDR_WIDTH + 1)) != 16'h0000;

  always_ff @(posedge clk) begin
    if (enter_ack && cm_write && !cm_oor) begin
      if (cm_be[0]) mem[cm_idx][7:0]  <= cm_wdata[7:0];
      if (cm_be[1]) mem[cm_idx][15:8] <= cm_wdata[15:8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_be    <= 2'b00;
      lat_addr  <= 16'h0000;
      lat_wdata <= 16'h0000;
      resp_q    <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= 16'h0000;
    end else begin
      resp_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            lat_write <= bus.dmem_write;
            lat_be    <= bus.dmem_byte_enable;
            lat_addr  <= bus.dmem_address;
            lat_wdata <= bus.dmem_wdata;
            if (LATENCY == 0) begin
              state <= ACK;
            end else begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (!bus.dmem_action_cyc) state <= IDLE;
          else if (cnt == '0)       state <= ACK;
          else                      cnt   <= cnt - 1'b1;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase

      if (enter_ack) begin
        resp_q <= 1'b1;
        err_q  <= cm_oor;
        if (cm_oor)         data_q <= 16'h0000;
        else if (!cm_write) data_q <= mem[cm_idx];
      end
    end
  end

  assign bus.dmem_resp     = resp_q;
  assign bus.dmem_err      = err_q;
  assign bus.dmem_data_out = data_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder. One instance runs
// with LATENCY=2 (bus a), one with LATENCY=0 (bus b). Stimulus pushes the
// expected response; per-bus monitors pop and compare on every dmem_resp.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if ifa ();
  dmem_responder_if ifb ();

  dmem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  dmem_responder #(.ADDR_WIDTH(8), .LATENCY(0)) u_l0 (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  typedef struct {
    bit          chk_data;
    logic [15:0] data;
    bit          err;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   tests = 0;
  int   fails = 0;
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (ifa.dmem_resp === 1'b1) begin
      check("a_no_double_resp", 32'(prev_a), 32'd0);
      if (qa.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL a_unexpected_resp: got resp 1 expected no resp at %0t", $time);
      end else begin
        ea = qa.pop_front();
        check("a_err", 32'(ifa.dmem_err), 32'(ea.err));
        if (ea.chk_data) check("a_data", 32'(ifa.dmem_data_out), 32'(ea.data));
      end
    end
    prev_a = ifa.dmem_resp;
  end

  always @(negedge clk) begin
    if (ifb.dmem_resp === 1'b1) begin
      check("b_no_double_resp", 32'(prev_b), 32'd0);
      if (qb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_unexpected_resp: got resp 1 expected no resp at %0t", $time);
      end else begin
        eb = qb.pop_front();
        check("b_err", 32'(ifb.dmem_err), 32'(eb.err));
        if (eb.chk_data) check("b_data", 32'(ifb.dmem_data_out), 32'(eb.data));
      end
    end
    prev_b = ifb.dmem_resp;
  end

  task automatic drive(input bit sel, input bit cyc, input bit stb, input bit wr,
                       input logic [1:0] be, input logic [15:0] addr, input logic [15:0] wd);
    if (!sel) begin
      ifa.dmem_action_cyc = cyc; ifa.dmem_action_stb = stb; ifa.dmem_write = wr;
      ifa.dmem_byte_enable = be; ifa.dmem_address = addr;   ifa.dmem_wdata = wd;
    end else begin
      ifb.dmem_action_cyc = cyc; ifb.dmem_action_stb = stb; ifb.dmem_write = wr;
      ifb.dmem_byte_enable = be; ifb.dmem_address = addr;   ifb.dmem_wdata = wd;
    end
  endtask

  function automatic logic resp_of(input bit sel);
    return sel ? ifb.dmem_resp : ifa.dmem_resp;
  endfunction

  // Called just after a falling edge. The first rising edge is the accept edge
  // (k=1); dmem_resp must first be seen on the falling edge after edge LATENCY+1.
  // During the wait, the request inputs are scrambled to prove they were latched.
  task automatic xact(input bit sel, input bit wr, input logic [1:0] be,
                      input logic [15:0] addr, input logic [15:0] wd,
                      input bit chk, input logic [15:0] exp_d, input bit exp_e,
                      input string name);
    exp_t e;
    int   got;
    int   lat;
    e.chk_data = chk; e.data = exp_d; e.err = exp_e;
    if (sel) qb.push_back(e); else qa.push_back(e);
    lat = sel ? 0 : 2;
    drive(sel, 1'b1, 1'b1, wr, be, addr, wd);
    got = 0;
    for (int k = 1; k <= 16 && got == 0; k++) begin
      @(negedge clk);
      if (resp_of(sel) === 1'b1) got = k;
      else drive(sel, 1'b1, 1'b0, !wr, ~be, addr ^ 16'h0002, ~wd);
    end
    drive(sel, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    check({name, "_latency"}, 32'(got), 32'(lat + 1));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int  t1, t2, n;
    logic abort_seen;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_resp", 32'(ifa.dmem_resp), 32'd0);
    check("rst_err",  32'(ifa.dmem_err),  32'd0);
    check("rst_data", 32'(ifa.dmem_data_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-word write then read, LATENCY=2
    xact(0, 1, 2'b11, 16'h0010, 16'h1234, 0, 16'h0000, 0, "w10");
    xact(0, 0, 2'b11, 16'h0010, 16'h0000, 1, 16'h1234, 0, "r10");

    // Byte-lane writes
    xact(0, 1, 2'b11, 16'h0020, 16'hAAAA, 0, 16'h0000, 0, "w20");
    xact(0, 1, 2'b01, 16'h0020, 16'h0055, 0, 16'h0000, 0, "w20_lo");
    xact(0, 1, 2'b10, 16'h0021, 16'h3300, 0, 16'h0000, 0, "w21_hi");
    xact(0, 0, 2'b00, 16'h0020, 16'h0000, 1, 16'h3355, 0, "r20");
    xact(0, 1, 2'b00, 16'h0020, 16'hFFFF, 0, 16'h0000, 0, "w20_none");
    xact(0, 0, 2'b11, 16'h0020, 16'h0000, 1, 16'h3355, 0, "r20_again");

    // Abort during WAIT: no resp, no write
    xact(0, 1, 2'b11, 16'h0030, 16'h5A5A, 0, 16'h0000, 0, "w30");
    drive(0, 1'b1, 1'b1, 1'b1, 2'b11, 16'h0030, 16'hBEEF);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    abort_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ifa.dmem_resp === 1'b1) abort_seen = 1'b1;
    end
    check("abort_no_resp", 32'(abort_seen), 32'd0);
    xact(0, 0, 2'b11, 16'h0030, 16'h0000, 1, 16'h5A5A, 0, "r30_after_abort");

    // Out of range
    xact(0, 1, 2'b11, 16'h0000, 16'h0BAD, 0, 16'h0000, 0, "w0");
    xact(0, 0, 2'b11, 16'h0400, 16'h0000, 1, 16'h0000, 1, "r400_oor");
    xact(0, 1, 2'b11, 16'h0400, 16'hDEAD, 1, 16'h0000, 1, "w400_oor");
    xact(0, 0, 2'b11, 16'h0000, 16'h0000, 1, 16'h0BAD, 0, "r0_after_oor");

    // Reset in the middle of WAIT of a write
    xact(0, 1, 2'b11, 16'h0040, 16'h1111, 0, 16'h0000, 0, "w40");
    xact(0, 0, 2'b11, 16'h0040, 16'h0000, 1, 16'h1111, 0, "r40");
    drive(0, 1'b1, 1'b1, 1'b1, 2'b11, 16'h0040, 16'h7777);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_resp", 32'(ifa.dmem_resp), 32'd0);
    check("midrst_err",  32'(ifa.dmem_err),  32'd0);
    check("midrst_data", 32'(ifa.dmem_data_out), 32'd0);
    drive(0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xact(0, 0, 2'b11, 16'h0040, 16'h0000, 1, 16'h1111, 0, "r40_after_rst");

    // LATENCY=0 instance: preload, single read, then back-to-back reads
    xact(1, 1, 2'b11, 16'h0002, 16'hC0DE, 0, 16'h0000, 0, "b_w2");
    xact(1, 1, 2'b11, 16'h0004, 16'hF00D, 0, 16'h0000, 0, "b_w4");
    xact(1, 0, 2'b11, 16'h0004, 16'h0000, 1, 16'hF00D, 0, "b_r4");

    begin
      exp_t e1, e2;
      e1.chk_data = 1; e1.data = 16'hC0DE; e1.err = 0;
      e2.chk_data = 1; e2.data = 16'hF00D; e2.err = 0;
      qb.push_back(e1);
      qb.push_back(e2);
    end
    drive(1, 1'b1, 1'b1, 1'b0, 2'b11, 16'h0002, 16'h0000);
    t1 = 0; t2 = 0; n = 0;
    for (int k = 1; k <= 12 && t2 == 0; k++) begin
      @(negedge clk);
      if (ifb.dmem_resp === 1'b1) begin
        n++;
        if (n == 1) begin
          t1 = k;
          drive(1, 1'b1, 1'b1, 1'b0, 2'b11, 16'h0004, 16'h0000);
        end else begin
          t2 = k;
        end
      end
    end
    drive(1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    check("b2b_first_resp", 32'(t1), 32'd1);
    check("b2b_second_resp", 32'(t2), 32'd3);
    repeat (3) @(negedge clk);

    check("qa_drained", 32'(qa.size()), 32'd0);
    check("qb_drained", 32'(qb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
